// File: rtl/phase_differentiator.sv
// Differentiates NCO phase samples back into FCW: a modulo-2^WIDTH delta per valid sample,
// averaged over 2^LOG2_AVG deltas with truncation.
module phase_differentiator #(
  parameter int WIDTH    = 32,
  parameter int LOG2_AVG = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] phase_in,
  input  logic             phase_valid_in,
  output logic [WIDTH-1:0] delta_out,
  output logic             delta_valid_out,
  output logic [WIDTH-1:0] fcw_out,
  output logic             fcw_valid_out,
  output logic             locked_out
);

  localparam int CW = (LOG2_AVG == 0) ? 1 : LOG2_AVG;
  localparam int SW = WIDTH + LOG2_AVG;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_AVG) - 1);

  typedef enum logic {PRIME, RUN} state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_prev;
  logic [SW-1:0]    r_sum;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_delta;
  logic [SW-1:0]    w_sum_nxt;
  logic             w_run, w_last;

  always_ff @(posedge clk) begin
    if (rst) r_state <= PRIME;
    else     r_state <= w_state_nxt;
  end

  // The first valid sample only primes r_prev; every later one produces a delta.
  always_comb begin
    w_state_nxt = r_state;
    w_run       = 1'b0;
    case (r_state)
      PRIME: if (phase_valid_in) w_state_nxt = RUN;
      RUN:   w_run = phase_valid_in;
      default: w_state_nxt = PRIME;
    endcase
  end

  assign w_delta   = phase_in - r_prev;
  assign w_sum_nxt = r_sum + SW'(w_delta);
  assign w_last    = (r_cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev          <= '0;
      r_sum           <= '0;
      r_cnt           <= '0;
      delta_out       <= '0;
      delta_valid_out <= 1'b0;
      fcw_out         <= '0;
      fcw_valid_out   <= 1'b0;
      locked_out      <= 1'b0;
    end else begin
      delta_valid_out <= 1'b0;
      fcw_valid_out   <= 1'b0;
      if (phase_valid_in) r_prev <= phase_in;
      if (w_run) begin
        delta_out       <= w_delta;
        delta_valid_out <= 1'b1;
        if (w_last) begin
          // The widened sum cannot overflow, so the shifted slice always fits WIDTH.
          fcw_out       <= w_sum_nxt[SW-1:LOG2_AVG];
          fcw_valid_out <= 1'b1;
          locked_out    <= 1'b1;
          r_sum         <= '0;
          r_cnt         <= '0;
        end else begin
          r_sum <= w_sum_nxt;
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_phase_differentiator.sv
// Scoreboard bench for phase_differentiator (WIDTH=32, LOG2_AVG=2).
module tb_phase_differentiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] phase_in = '0;
  logic        phase_valid_in = 1'b0;
  logic [31:0] delta_out, fcw_out;
  logic        delta_valid_out, fcw_valid_out, locked_out;

  phase_differentiator #(.WIDTH(32), .LOG2_AVG(2)) dut (
    .clk(clk), .rst(rst), .phase_in(phase_in), .phase_valid_in(phase_valid_in),
    .delta_out(delta_out), .delta_valid_out(delta_valid_out),
    .fcw_out(fcw_out), .fcw_valid_out(fcw_valid_out), .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_dp  = 0;
  int n_fp  = 0;

  logic [31:0] qd[$];
  logic [31:0] qf[$];

  // Reference model of the spec behaviour, fed as stimulus is driven.
  bit          m_primed = 0;
  logic [31:0] m_prev   = '0;
  logic [33:0] m_sum    = '0;
  int          m_cnt    = 0;

  function automatic void model_sample(input logic [31:0] ph);
    logic [31:0] d;
    if (!m_primed) begin
      m_primed = 1;
    end else begin
      d = ph - m_prev;
      qd.push_back(d);
      m_sum = m_sum + {2'b00, d};
      if (m_cnt == 3) begin
        qf.push_back(m_sum[33:2]);
        m_sum = '0;
        m_cnt = 0;
      end else begin
        m_cnt = m_cnt + 1;
      end
    end
    m_prev = ph;
  endfunction

  // Output side of the scoreboard: pop and compare on every pulse.
  always @(negedge clk) begin
    logic [31:0] e;
    if (delta_valid_out) begin
      n_dp++;
      total++;
      if (qd.size() == 0) begin
        bad++;
        $display("FAIL delta_unexpected: got pulse with delta_out=%0d, none expected", delta_out);
      end else begin
        e = qd.pop_front();
        if (delta_out !== e) begin
          bad++;
          $display("FAIL delta_value: got %0d expected %0d", delta_out, e);
        end
      end
    end
    if (fcw_valid_out) begin
      n_fp++;
      total++;
      if (qf.size() == 0) begin
        bad++;
        $display("FAIL fcw_unexpected: got pulse with fcw_out=%0d, none expected", fcw_out);
      end else begin
        e = qf.pop_front();
        if (fcw_out !== e) begin
          bad++;
          $display("FAIL fcw_value: got %0d expected %0d", fcw_out, e);
        end
      end
    end
  end

  task automatic drive(input logic [31:0] ph);
    @(posedge clk); #1;
    phase_in = ph;
    phase_valid_in = 1'b1;
    model_sample(ph);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      phase_valid_in = 1'b0;
    end
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b1;
    phase_valid_in = 1'b0;
    repeat (n) @(posedge clk);
    #1 rst = 1'b0;
    m_primed = 0;
    m_sum = '0;
    m_cnt = 0;
  endtask

  task automatic drain(input string name);
    idle(2);
    total++;
    if (qd.size() != 0 || qf.size() != 0) begin
      bad++;
      $display("FAIL %s_drain: pending deltas=%0d fcws=%0d, required 0", name, qd.size(), qf.size());
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      total++;
      if ({delta_out, fcw_out, delta_valid_out, fcw_valid_out, locked_out} !== '0) begin
        bad++;
        $display("FAIL reset_outputs: delta=%0h fcw=%0h dv=%b fv=%b lk=%b, required all 0",
                 delta_out, fcw_out, delta_valid_out, fcw_valid_out, locked_out);
      end
    end
    #1 rst = 1'b0;
    drive(32'd100);
    idle(1);
    @(negedge clk);
    total++;
    if (delta_valid_out !== 1'b0 || locked_out !== 1'b0) begin
      bad++;
      $display("FAIL prime_no_delta: dv=%b lk=%b, required 0 0", delta_valid_out, locked_out);
    end
    drain("reset");
  endtask

  task automatic test_constant();
    int d0, f0;
    do_reset(2);
    d0 = n_dp; f0 = n_fp;
    for (int k = 0; k < 5; k++) drive(32'(k * 5));
    @(negedge clk);
    total++;
    if (locked_out !== 1'b0) begin
      bad++;
      $display("FAIL const_early_lock: locked_out=%b before window end, required 0", locked_out);
    end
    idle(1);
    @(negedge clk);
    total++;
    if (fcw_valid_out !== 1'b1 || delta_valid_out !== 1'b1 || locked_out !== 1'b1 || fcw_out !== 32'd5) begin
      bad++;
      $display("FAIL const_window: fv=%b dv=%b lk=%b fcw=%0d, required 1 1 1 5",
               fcw_valid_out, delta_valid_out, locked_out, fcw_out);
    end
    drain("const");
    total++;
    if (n_dp - d0 != 4 || n_fp - f0 != 1) begin
      bad++;
      $display("FAIL const_pulses: deltas=%0d fcws=%0d, required 4 1", n_dp - d0, n_fp - f0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] ph;
    do_reset(1);
    drive(32'hFFFF_FFF0);
    drive(32'h0000_0010);
    idle(1);
    @(negedge clk);
    total++;
    if (delta_out !== 32'h0000_0020) begin
      bad++;
      $display("FAIL wrap_delta: got %h expected 00000020", delta_out);
    end
    drain("wrap");
    do_reset(1);
    ph = 32'd0;
    for (int k = 0; k < 9; k++) begin
      drive(ph);
      ph = ph + 32'd600000000;
    end
    drain("wrap_fcw");
    total++;
    if (fcw_out !== 32'd600000000) begin
      bad++;
      $display("FAIL wrap_fcw: got %0d expected 600000000", fcw_out);
    end
  endtask

  task automatic test_truncation();
    do_reset(1);
    drive(0); drive(1); drive(3); drive(6); drive(12);
    idle(1);
    @(negedge clk);
    total++;
    if (fcw_out !== 32'd3) begin
      bad++;
      $display("FAIL trunc_first: got %0d expected 3", fcw_out);
    end
    drive(13); drive(14); drive(15); drive(17);
    drain("trunc");
    total++;
    if (fcw_out !== 32'd1) begin
      bad++;
      $display("FAIL trunc_second: got %0d expected 1", fcw_out);
    end
  endtask

  task automatic test_gapped();
    int d0, f0;
    do_reset(1);
    d0 = n_dp; f0 = n_fp;
    for (int k = 0; k < 5; k++) begin
      drive(32'(k * 5));
      idle($urandom_range(0, 3));
    end
    drain("gap");
    total++;
    if (n_dp - d0 != 4 || n_fp - f0 != 1 || fcw_out !== 32'd5) begin
      bad++;
      $display("FAIL gap_pulses: deltas=%0d fcws=%0d fcw=%0d, required 4 1 5",
               n_dp - d0, n_fp - f0, fcw_out);
    end
  endtask

  task automatic test_mid_reset();
    int d0;
    do_reset(1);
    drive(0); drive(7); drive(14);
    do_reset(1);
    total++;
    if (locked_out !== 1'b0) begin
      bad++;
      $display("FAIL midrst_lock: locked_out=%b after reset, required 0", locked_out);
    end
    d0 = n_dp;
    drive(1000);
    idle(1);
    @(negedge clk);
    total++;
    if (n_dp != d0) begin
      bad++;
      $display("FAIL midrst_prime: %0d deltas on first sample, required 0", n_dp - d0);
    end
    drive(1004); drive(1008); drive(1012); drive(1016);
    drain("midrst");
    total++;
    if (fcw_out !== 32'd4 || locked_out !== 1'b1) begin
      bad++;
      $display("FAIL midrst_fcw: fcw=%0d lk=%b, required 4 1", fcw_out, locked_out);
    end
  endtask

  task automatic test_back_to_back();
    int f0;
    do_reset(1);
    f0 = n_fp;
    for (int k = 0; k < 17; k++) drive(32'(k * 123457));
    drain("b2b");
    total++;
    if (n_fp - f0 != 4 || fcw_out !== 32'd123457) begin
      bad++;
      $display("FAIL b2b_fcw: fcws=%0d fcw=%0d, required 4 123457", n_fp - f0, fcw_out);
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_wrap();
    test_truncation();
    test_gapped();
    test_mid_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_differentiator.md
# phase_differentiator

Recovers the frequency control word (FCW) from a stream of phase-accumulator samples. It is the inverse of the NCO phase accumulator: the accumulator integrates the FCW into phase, and this block differentiates phase back into FCW. Each delta is the modulo-2^WIDTH difference between consecutive valid samples, and the block averages the deltas over a fixed window. It sits on the NCO monitor path and checks that the accumulator runs at the programmed tuning word.

## Interface
- WIDTH, 32: phase and FCW width in bits.
- LOG2_AVG, 2: log2 of the averaging window length N = 2^LOG2_AVG deltas. Legal range is 0 to 8.

- clk  input  1  system clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- phase_in  input  WIDTH  accumulator phase sample, unsigned.
- phase_valid_in  input  1  phase_in is valid this cycle.
- delta_out  output  WIDTH  latest instantaneous phase difference.
- delta_valid_out  output  1  one-cycle pulse when delta_out updates.
- fcw_out  output  WIDTH  latest averaged FCW estimate.
- fcw_valid_out  output  1  one-cycle pulse when fcw_out updates.
- locked_out  output  1  high once at least one fcw_out has been produced since reset.

## Operation
- Registers:
  - prev_reg (WIDTH): previous valid sample.
  - sum_reg (WIDTH+LOG2_AVG): window accumulator.
  - cnt_reg (LOG2_AVG bits, or 1 bit when LOG2_AVG=0): number of deltas in the current window.
  - state: PRIME or RUN.
- PRIME (entered at reset):
  - On phase_valid_in: prev_reg <= phase_in, go to RUN.
  - No delta is produced in this state.
- RUN, on each cycle with phase_valid_in:
  - d = (phase_in - prev_reg) mod 2^WIDTH, unsigned. No sign handling.
  - prev_reg <= phase_in.
  - delta_out <= d; delta_valid_out pulses.
  - If cnt_reg < N-1: sum_reg <= sum_reg + d; cnt_reg <= cnt_reg + 1.
  - If cnt_reg == N-1:
    - fcw_out <= (sum_reg + d) >> LOG2_AVG, truncated (no rounding).
    - fcw_valid_out pulses; locked_out <= 1.
    - sum_reg <= 0; cnt_reg <= 0.
- Cycles with phase_valid_in low: all registers hold and both valid pulses are low. Gaps of any length do not change the results.
- sum_reg is sized WIDTH+LOG2_AVG so it never overflows within a window. The shifted result always fits in WIDTH bits.
- Reset:
  - delta_out, fcw_out, sum_reg, cnt_reg and prev_reg = 0.
  - delta_valid_out, fcw_valid_out and locked_out = 0.
  - state = PRIME.
  - Reset has priority over phase_valid_in in the same cycle.
- Reset mid-window discards the partial sum. The first valid sample after reset only primes prev_reg.
- No backpressure: the block accepts one sample per cycle, every cycle.

## Timing
- delta_out and delta_valid_out are registered one cycle after the input cycle that supplied the sample.
- fcw_out and fcw_valid_out are registered in the same cycle as the delta_valid_out of the window's final delta, which is also one cycle after input.
- The first delta appears on the second valid sample after reset.
- The first fcw_out appears on valid sample N+1 after reset.
- Sustained throughput: one delta per cycle, one FCW per N valid samples.
- Valid pulses are exactly one cycle wide, even for back-to-back valid inputs.
- Output data holds between pulses.

## Test plan
1. Reset and prime:
   - Stimulus: hold rst for 3 cycles, then phase 100 with valid.
   - Required: all outputs 0 during reset; no delta_valid_out after the first sample; locked_out = 0.
2. Constant FCW with LOG2_AVG=2:
   - Stimulus: samples 0, 5, 10, 15, 20 on consecutive cycles.
   - Required: delta_out = 5 with a pulse on each of 4 cycles; fcw_out = 5 with fcw_valid_out on the 4th delta pulse; locked_out rises with it.
3. Wrap-around:
   - Stimulus: samples 0xFFFFFFF0, then 0x00000010.
   - Required: delta_out = 0x00000020.
   - Stimulus: FCW 600000000 run past 2^32.
   - Required: every delta = 600000000 and fcw_out = 600000000.
4. Averaging and truncation:
   - Stimulus: deltas 1, 2, 3, 6.
   - Required: fcw_out = 3.
   - Stimulus: next window with deltas 1, 1, 1, 2.
   - Required: fcw_out = 1 (5>>2).
5. Gapped valid:
   - Stimulus: the scenario 2 sequence with 0–3 idle cycles randomly inserted between samples.
   - Required: identical delta and fcw values; no pulses on idle cycles.
6. Reset mid-window:
   - Stimulus: after 2 deltas of 7, assert rst for 1 cycle, then send samples 1000, 1004, 1008, 1012, 1016.
   - Required: no delta for sample 1000; fcw_out = 4 after 4 deltas; no contribution from the pre-reset 7s.
